// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage that sits after the ALU.
// Non-memory ops retire to writeback one cycle after en. LD/ST/PUSH/POP run
// a req/ack bus access, and busy holds the pipeline until the op retires.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, an access that
// gets no mem_ack within TIMEOUT cycles is abandoned and bus_err is pulsed.
module mem_stage #(
  parameter int SP_INDEX = 7,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  alu_control,
  input  logic [15:0] alu_out,
  input  logic [15:0] alu_mem_data,
  input  logic        alu_write,
  input  logic [15:0] sp_in,
  input  logic [2:0]  rd_addr,
  output logic        busy,
  output logic        done,
  output logic        wb_en,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        sp_wb_en,
  output logic [15:0] sp_wb_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  // Opcode encodings shared with the ALU's decoder
  localparam logic [7:0] OPC_LD   = 8'h20;
  localparam logic [7:0] OPC_ST   = 8'h21;
  localparam logic [7:0] OPC_PUSH = 8'h22;
  localparam logic [7:0] OPC_POP  = 8'h23;

  localparam logic [2:0] SP_IDX = 3'(SP_INDEX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WB     = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_op;
  logic [2:0]  r_rd;
  logic [15:0] r_sp;
  logic        w_is_mem;
  logic        w_start_alu;
  logic        w_start_mem;
  logic        w_ack;
  logic        w_tmo;

  // Decode the incoming op and compute the next FSM state
  always_comb begin
    w_is_mem     = (alu_control == OPC_LD) || (alu_control == OPC_ST) ||
                   (alu_control == OPC_PUSH) || (alu_control == OPC_POP);
    w_start_alu  = (r_state == S_IDLE) && en && !w_is_mem;
    w_start_mem  = (r_state == S_IDLE) && en && w_is_mem;
    w_ack        = (r_state == S_ACCESS) && mem_ack;
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_mem) w_state_next = S_ACCESS;
      S_ACCESS: begin
        if (w_ack)      w_state_next = S_WB;
        else if (w_tmo) w_state_next = S_IDLE;
      end
      S_WB:     w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] r_tmo_cnt;

  // Count ACCESS cycles that pass without an ack; cleared when an access starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_tmo_cnt <= '0;
    else if (w_start_mem)                     r_tmo_cnt <= '0;
    else if ((r_state == S_ACCESS) && !mem_ack) r_tmo_cnt <= r_tmo_cnt + 16'd1;
  end

  // The count reaches TIMEOUT this cycle; a simultaneous ack takes priority
  assign w_tmo = (r_state == S_ACCESS) && !mem_ack && (r_tmo_cnt == TMO_LAST);
`else
  assign w_tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Hold the memory op's context for writeback after the access completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op <= '0;
      r_rd <= '0;
      r_sp <= '0;
    end else if (w_start_mem) begin
      r_op <= alu_control;
      r_rd <= rd_addr;
      r_sp <= sp_in;
    end
  end

  // Registered outputs; the strobes default low so each one is a single-cycle pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      sp_wb_en   <= 1'b0;
      sp_wb_data <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      bus_err    <= 1'b0;
    end else begin
      done     <= 1'b0;
      wb_en    <= 1'b0;
      sp_wb_en <= 1'b0;
      bus_err  <= 1'b0;
      busy     <= (w_state_next != S_IDLE);
      if (w_start_alu) begin
        done    <= 1'b1;
        wb_en   <= alu_write;
        wb_addr <= rd_addr;
        wb_data <= alu_out;
      end
      if (w_start_mem) begin
        mem_req   <= 1'b1;
        mem_we    <= (alu_control == OPC_ST) || (alu_control == OPC_PUSH);
        mem_addr  <= alu_out;
        mem_wdata <= alu_mem_data;
      end
      if (w_ack) begin
        // Entering WB: read data is captured straight into wb_data
        mem_req    <= 1'b0;
        done       <= 1'b1;
        wb_addr    <= r_rd;
        wb_data    <= mem_rdata;
        sp_wb_data <= r_sp;
        case (r_op)
          OPC_LD:   wb_en <= 1'b1;
          OPC_PUSH: sp_wb_en <= 1'b1;
          OPC_POP: begin
            wb_en    <= 1'b1;
            // Popping into the SP itself: the loaded value wins
            sp_wb_en <= (r_rd != SP_IDX);
          end
          default: ;
        endcase
      end
      if (w_tmo) begin
        mem_req <= 1'b0;
        done    <= 1'b1;
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the ALU.
- Consumes the registered ALU result, store data, write-enable and updated SP.
- Performs the data-memory access for LD/ST/PUSH/POP over a req/ack bus. Produces register-file and SP writeback.
- Non-memory ops pass straight through to writeback in one cycle. Memory ops stall the pipeline via busy until the access completes.

Parameters:
- SP_INDEX, 7: register-file index of the stack pointer.
- TIMEOUT, 255: max cycles mem_req waits for mem_ack. Used only with MEM_TIMEOUT_EN; legal range 1..65535.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  ALU result valid this cycle. Sampled only in IDLE.
- alu_control  input  8  opcode, encodings from cpu_constants.vh (OPC_LD, OPC_ST, OPC_PUSH, OPC_POP).
- alu_out  input  16  ALU result. Memory address for memory ops, writeback data otherwise.
- alu_mem_data  input  16  store data for ST/PUSH.
- alu_write  input  1  ALU requests register writeback (non-memory ops).
- sp_in  input  16  updated SP from ALU (PUSH/POP).
- rd_addr  input  3  destination register index.
- busy  output  1  stage occupied; upstream must hold.
- done  output  1  one-cycle pulse on instruction retire.
- wb_en  output  1  register-file write strobe.
- wb_addr  output  3  register-file write index.
- wb_data  output  16  register-file write data.
- sp_wb_en  output  1  SP write strobe.
- sp_wb_data  output  16  SP write data.
- mem_req  output  1  bus request, held until ack.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  output  16  bus address.
- mem_wdata  output  16  bus write data.
- mem_rdata  input  16  bus read data, valid with mem_ack.
- mem_ack  input  1  bus completion, one cycle.
- bus_err  output  1  timeout pulse (MEM_TIMEOUT_EN only).

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0, including mem_req, busy, done, wb_en, sp_wb_en and bus_err; data/address outputs are 0. An in-flight access is abandoned with no writeback.
- States:
  - IDLE: accept work.
  - ACCESS: mem_req high.
  - WB: retire memory op.
- busy = (state != IDLE), registered.
- IDLE, en=1, non-memory op: next cycle done=1, wb_en=alu_write, wb_addr=rd_addr, wb_data=alu_out; stay IDLE. Latency 1; back-to-back en accepted every cycle.
- IDLE, en=1, memory op: latch alu_out->mem_addr, alu_mem_data->mem_wdata, rd_addr, sp_in, opcode. Next cycle: state=ACCESS, mem_req=1, mem_we=1 for ST/PUSH and 0 for LD/POP.
- ACCESS: mem_req and mem_addr/mem_wdata/mem_we held stable until mem_ack. An ack in the first ACCESS cycle is legal. On mem_ack: mem_req=0 next cycle, capture mem_rdata, go to WB.
- WB (one cycle), done=1, then IDLE. Per opcode:
  - LD: wb_en=1, wb_data=captured rdata.
  - ST: no strobes.
  - PUSH: sp_wb_en=1, sp_wb_data=latched sp_in.
  - POP: wb_en=1 with rdata, plus sp_wb_en=1 with latched sp_in, same cycle.
- POP with rd_addr==SP_INDEX: the loaded value wins and sp_wb_en is suppressed.
- Minimum memory-op latency: en at t0, req t1, ack t1, WB/done t2. busy is high at t1..t2 and low at t3.
- mem_ack while not in ACCESS is ignored.
- en while busy is ignored.
- Strobes (wb_en, sp_wb_en, done, bus_err) are single-cycle pulses.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack. When it reaches TIMEOUT:
  - mem_req drops next cycle;
  - bus_err=1 and done=1 for one cycle;
  - no wb_en/sp_wb_en;
  - return to IDLE.
- An ack arriving on the same cycle the count reaches TIMEOUT wins: normal completion, no bus_err.
- Undefined: no counter, ACCESS waits indefinitely, bus_err tied 0.

Test Plan:
- OPC_ADD, en=1, alu_out=16'h1234, alu_write=1, rd_addr=3 -> next cycle wb_en=1, wb_addr=3, wb_data=16'h1234, done=1, busy=0.
- OPC_LD, alu_out=16'h0040, rd_addr=2, ack after 3 cycles with mem_rdata=16'hBEEF -> mem_req=1/mem_we=0/mem_addr=16'h0040 for 3 cycles; then wb_en=1, wb_addr=2, wb_data=16'hBEEF; busy high throughout.
- OPC_PUSH, alu_out=16'h0FFE, alu_mem_data=16'h00AA, sp_in=16'h0FFE, immediate ack -> mem_we=1, mem_wdata=16'h00AA; then sp_wb_en=1, sp_wb_data=16'h0FFE, wb_en=0.
- OPC_POP, alu_out=16'h0FFE, sp_in=16'h1000, mem_rdata=16'h5555, rd_addr=1 -> WB cycle has wb_en=1 (r1=16'h5555) and sp_wb_en=1 (16'h1000). Repeat with rd_addr=7 -> sp_wb_en=0, wb_data=16'h5555.
- rst asserted mid-ACCESS (LD outstanding) -> mem_req/busy drop immediately; later mem_ack ignored; no wb_en.
- MEM_TIMEOUT_EN, TIMEOUT=4, no ack -> mem_req high 4 cycles, then bus_err=1 and done=1 pulse, wb_en=0, state IDLE.
